// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall, squash, divide-interlock and exception sequencing for the 5-stage core
module hazard_control_unit #(
    parameter int DIV_CYCLES  = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_hilo_access,
    input  logic                   id_redirect,
    input  logic                   id_break,
    input  logic                   id_syscall,
    input  logic                   id_reserved,
    input  logic                   id_eret,
    input  logic                   ext_interrupt,
    input  logic                   ex_l_type,
    input  logic                   ex_reg_write,
    input  logic [4:0]             ex_wb_addr,
    input  logic                   ex_div_start,
    output logic                   pc_write_en,
    output logic                   if_id_write_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic [1:0]             pc_sel,
    output logic                   epc_write,
    output logic [4:0]             cause_code,
    output logic                   div_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {NORMAL, DIV_BUSY, EXC_HOLD} state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state, state_next;
    logic [5:0] div_cnt, div_cnt_next;
    logic       busy, load_use, hilo_stall, id_exc, irq, take_exc, stall;

    assign busy       = div_cnt != 6'd0;
    assign load_use   = ex_l_type & ex_reg_write & (ex_wb_addr != 5'd0) &
                        ((id_uses_rs & (id_rs == ex_wb_addr)) | (id_uses_rt & (id_rt == ex_wb_addr)));
    assign hilo_stall = id_hilo_access & busy;
    assign id_exc     = id_break | id_syscall | id_reserved;
    assign irq        = ext_interrupt & (state != EXC_HOLD);
    assign take_exc   = id_exc | irq;
    assign stall      = load_use | hilo_stall;
    assign div_busy   = ~reset & busy;

    // Pipeline controls act in the same cycle as the hazard, highest-priority action wins
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        pc_sel         = 2'd0;
        epc_write      = 1'b0;
        cause_code     = 5'd0;
        if (reset) begin
        end else if (take_exc) begin
            pc_sel      = 2'd1;
            epc_write   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            cause_code  = id_reserved ? 5'd10 : id_break ? 5'd9 : id_syscall ? 5'd8 : 5'd0;
        end else if (id_eret) begin
            pc_sel      = 2'd2;
            if_id_flush = 1'b1;
        end else if (stall) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end else if (id_redirect) begin
            if_id_flush = 1'b1;
        end
    end

    // Divider keeps counting through exceptions so HI/LO completion is never cancelled
    always_comb begin
        div_cnt_next = ex_div_start ? DIV_LOAD : busy ? div_cnt - 6'd1 : div_cnt;
        state_next   = (take_exc | id_eret) ? EXC_HOLD : (div_cnt_next != 6'd0) ? DIV_BUSY : NORMAL;
    end

    // State, divide counter and saturating stall counter advance with the pipeline registers
    always_ff @(negedge clock) begin
        if (reset) begin
            state       <= NORMAL;
            div_cnt     <= 6'd0;
            stall_count <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
            if (!pc_write_en && stall_count != '1)
                stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of stalls, divide interlock, squash, exceptions and reset
module tb_hazard_control_unit;
    logic        clock = 1'b1;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_wb_addr;
    logic        id_uses_rs, id_uses_rt, id_hilo_access, id_redirect;
    logic        id_break, id_syscall, id_reserved, id_eret, ext_interrupt;
    logic        ex_l_type, ex_reg_write, ex_div_start;
    logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, epc_write, div_busy;
    logic [1:0]  pc_sel;
    logic [4:0]  cause_code;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_control_unit #(.DIV_CYCLES(4), .STALL_CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_hilo_access(id_hilo_access), .id_redirect(id_redirect),
        .id_break(id_break), .id_syscall(id_syscall), .id_reserved(id_reserved), .id_eret(id_eret),
        .ext_interrupt(ext_interrupt),
        .ex_l_type(ex_l_type), .ex_reg_write(ex_reg_write), .ex_wb_addr(ex_wb_addr),
        .ex_div_start(ex_div_start),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pc_sel(pc_sel),
        .epc_write(epc_write), .cause_code(cause_code), .div_busy(div_busy),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 0; id_rs = 0; id_rt = 0; ex_wb_addr = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_hilo_access = 0; id_redirect = 0;
        id_break = 0; id_syscall = 0; id_reserved = 0; id_eret = 0; ext_interrupt = 0;
        ex_l_type = 0; ex_reg_write = 0; ex_div_start = 0;
    endtask

    // inputs settle after the falling edge; outputs are observed at the rising edge
    task automatic sample();
        @(posedge clock);
    endtask

    task automatic advance();
        @(negedge clock);
        #1;
    endtask

    task automatic load_use_rs5();
        ex_l_type = 1; ex_reg_write = 1; ex_wb_addr = 5; id_uses_rs = 1; id_rs = 5;
    endtask

    initial begin
        idle();
        reset = 1;
        load_use_rs5();
        ext_interrupt = 1;
        sample();
        check("rst_pc_we", pc_write_en, 1);
        check("rst_ifid_we", if_id_write_en, 1);
        check("rst_flushes", {if_id_flush, id_ex_flush}, 0);
        check("rst_pc_sel", pc_sel, 0);
        check("rst_epc", epc_write, 0);
        advance();
        check("rst_stall_count", stall_count, 0);
        check("rst_div_busy", div_busy, 0);

        // load-use on rs
        idle(); load_use_rs5();
        sample();
        check("lu_pc_we", pc_write_en, 0);
        check("lu_ifid_we", if_id_write_en, 0);
        check("lu_idex_flush", id_ex_flush, 1);
        check("lu_ifid_flush", if_id_flush, 0);
        advance();
        check("lu_count", stall_count, 1);
        idle();
        sample();
        check("lu_after_pc_we", pc_write_en, 1);
        advance();
        idle(); load_use_rs5(); ex_wb_addr = 0; id_rs = 0;
        sample();
        check("lu_r0_no_stall", pc_write_en, 1);
        advance();
        idle(); ex_l_type = 1; ex_reg_write = 1; ex_wb_addr = 7; id_uses_rt = 1; id_rt = 7;
        sample();
        check("lu_rt_stall", pc_write_en, 0);
        advance();
        check("lu_rt_count", stall_count, 2);
        id_uses_rt = 0;
        sample();
        check("lu_rt_unused", pc_write_en, 1);
        advance();

        // divide interlock: mflo stalls while the 4-cycle divider runs
        idle(); ex_div_start = 1;
        sample();
        check("div_start_busy", div_busy, 0);
        advance();
        idle(); id_hilo_access = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("div_busy_%0d", i), div_busy, i < 3);
            check($sformatf("div_pc_we_%0d", i), pc_write_en, i >= 3);
            advance();
        end
        check("div_count", stall_count, 5);
        idle(); ex_div_start = 1;
        advance();
        idle(); id_uses_rs = 1; id_rs = 3;
        sample();
        check("div_add_busy", div_busy, 1);
        check("div_add_no_stall", pc_write_en, 1);
        advance();
        idle();
        repeat (3) advance();

        // branch squash, and stall beating redirect
        idle(); id_redirect = 1;
        sample();
        check("br_ifid_flush", if_id_flush, 1);
        check("br_pc_we", pc_write_en, 1);
        check("br_idex_flush", id_ex_flush, 0);
        advance();
        load_use_rs5();
        sample();
        check("br_lu_ifid_flush", if_id_flush, 0);
        check("br_lu_pc_we", pc_write_en, 0);
        check("br_lu_idex_flush", id_ex_flush, 1);
        advance();
        check("br_lu_count", stall_count, 6);

        // exception priority and irq masking in EXC_HOLD
        idle(); id_syscall = 1; ext_interrupt = 1;
        sample();
        check("exc_cause", cause_code, 8);
        check("exc_epc", epc_write, 1);
        check("exc_pc_sel", pc_sel, 1);
        check("exc_flushes", {if_id_flush, id_ex_flush}, 2'b11);
        check("exc_pc_we", pc_write_en, 1);
        advance();
        id_syscall = 0;
        sample();
        check("hold_no_epc", epc_write, 0);
        check("hold_pc_sel", pc_sel, 0);
        advance();
        sample();
        check("irq_epc", epc_write, 1);
        check("irq_cause", cause_code, 0);
        check("irq_pc_sel", pc_sel, 1);
        advance();
        idle(); id_break = 1; id_reserved = 1;
        sample();
        check("ri_over_break", cause_code, 10);
        advance();
        id_reserved = 0;
        sample();
        check("break_in_hold", cause_code, 9);
        check("break_in_hold_epc", epc_write, 1);
        advance();
        idle();
        advance();

        // eret
        idle(); id_eret = 1; load_use_rs5();
        sample();
        check("eret_pc_sel", pc_sel, 2);
        check("eret_ifid_flush", if_id_flush, 1);
        check("eret_idex_flush", id_ex_flush, 0);
        check("eret_pc_we", pc_write_en, 1);
        check("eret_epc", epc_write, 0);
        advance();
        idle();
        advance();

        // reserved instruction while dividing; counter keeps running
        idle(); ex_div_start = 1;
        advance();
        idle(); id_reserved = 1;
        sample();
        check("ri_div_cause", cause_code, 10);
        check("ri_div_busy", div_busy, 1);
        advance();
        idle();
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("ri_div_drain_%0d", i), div_busy, i < 2);
            advance();
        end

        // reset mid-divide
        idle(); ex_div_start = 1;
        advance();
        idle(); reset = 1;
        sample();
        check("rst_mid_busy_forced", div_busy, 0);
        advance();
        idle();
        sample();
        check("rst_mid_busy", div_busy, 0);
        check("rst_mid_count", stall_count, 0);
        check("rst_mid_idle", {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, epc_write}, 5'b11000);
        advance();

        // stall counter saturation
        idle(); load_use_rs5();
        repeat (65541) @(negedge clock);
        #1;
        check("sat_count", stall_count, 16'hFFFF);
        sample();
        check("sat_pc_we", pc_write_en, 0);
        advance();
        check("sat_hold", stall_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
